// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;
  localparam int          ITER_CNT  = 32;
endpackage

// File: rtl/muldiv_unit_operand_cond.sv
// Operand conditioning: per-op signedness, operand magnitudes and sign flags.
module operand_cond import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  op_e             op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            a_neg,
  output logic            b_neg
);
  logic a_sgn, b_sgn;

  always_comb begin
    a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
            (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// MULDIV_FAST_MUL_EN: MUL-class ops use a single-cycle 33x33 signed multiply.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wr_en
);
  state_e state, state_nxt;
  op_e op_i, op_q;
  logic [4:0] cnt, rd_q;
  logic fin, quick_q, neg_q, neg_r;
  logic [2*XLEN-1:0] acc, mul_nxt, div_nxt, prod_fix;
  logic [XLEN-1:0] opnd, a_mag, b_mag, quick_res, quot, rem, fin_res;
  logic a_neg, b_neg, accept, is_div, div0, ovf, quick;
  logic [XLEN:0] sum, sh, diff;

  assign op_i = op_e'(op);

  operand_cond #(.XLEN(XLEN)) u_cond (
    .op(op_i), .a(rs1_data), .b(rs2_data),
    .a_mag(a_mag), .b_mag(b_mag), .a_neg(a_neg), .b_neg(b_neg)
  );

  assign accept = start && !flush && (state == S_IDLE || state == S_DONE);
  assign is_div = op[2];
  assign div0   = is_div && (rs2_data == '0);
  assign ovf    = (op_i == OP_DIV || op_i == OP_REM) && (rs1_data == OVF_QUOT) && (rs2_data == '1);

  // Special results are resolved at accept and parked in acc for one busy cycle.
`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fprod;
  assign fprod = $signed({a_neg, rs1_data}) * $signed({b_neg, rs2_data});
  assign quick = div0 || ovf || !is_div;
`else
  assign quick = div0 || ovf;
`endif

  always_comb begin
    quick_res = op[1] ? (div0 ? rs1_data : '0) : (div0 ? DIV0_QUOT : OVF_QUOT);
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div) quick_res = (op_i == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = accept ? (is_div ? S_DIV : S_MUL) : S_IDLE;
      S_MUL, S_DIV: begin
        if (flush)    state_nxt = S_IDLE;
        else if (fin) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy  = (state == S_MUL) || (state == S_DIV);
  assign done  = (state == S_DONE);
  assign wr_en = done && (rd_out != '0);

  // acc = {high/remainder, low/multiplier-or-quotient}
  assign sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {sum, acc[XLEN-1:1]};
  assign sh      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff    = sh - {1'b0, opnd};
  assign div_nxt = diff[XLEN] ? {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign quot     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    if (quick_q)              fin_res = acc[XLEN-1:0];
    else if (state == S_DIV)  fin_res = op_q[1] ? rem : quot;
    else if (op_q == OP_MUL)  fin_res = prod_fix[XLEN-1:0];
    else                      fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; fin <= 1'b0; quick_q <= 1'b0; acc <= '0; opnd <= '0;
      op_q <= OP_MUL; rd_q <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
      result <= '0; rd_out <= '0;
    end else if (accept) begin
      op_q    <= op_i;
      rd_q    <= rd_in;
      cnt     <= '0;
      fin     <= quick;
      quick_q <= quick;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      opnd    <= is_div ? b_mag : a_mag;
      acc     <= {{XLEN{1'b0}}, quick ? quick_res : (is_div ? a_mag : b_mag)};
    end else if (busy && !flush) begin
      if (fin) begin
        result <= fin_res;
        rd_out <= rd_q;
      end else begin
        acc <= (state == S_DIV) ? div_nxt : mul_nxt;
        cnt <= cnt + 1'b1;
        fin <= (cnt == 5'(ITER_CNT - 1));
      end
    end
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  issue request; accepted only when busy=0.
REQ-005 op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rs1_data  input  32  operand A, from register-file rdata1.
REQ-007 rs2_data  input  32  operand B, from register-file rdata2.
REQ-008 rd_in  input  5  destination register of the issued op.
REQ-009 flush  input  1  abort the in-flight op.
REQ-010 busy  output  1  op in flight; upstream shall hold off start.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 result  output  32  registered result.
REQ-013 rd_out  output  5  destination register latched at accept.
REQ-014 wr_en  output  1  register-file write strobe, equal to done AND (rd_out != 0).

Function
REQ-015 FSM states are IDLE, MUL, DIV and DONE; busy=1 in MUL and DIV only.
REQ-016 IDLE or DONE with start=1 and flush=0: latch operands, op and rd_in, then go to MUL (op<4) or DIV (op>=4).
REQ-017 MUL runs 32 shift-add iterations on operand magnitudes into a 64-bit product, one iteration per cycle, with a 5-bit counter.
REQ-018 DIV runs 32 restoring iterations on operand magnitudes, one per cycle.
REQ-019 Sign rules: MULH signed x signed; MULHSU signed A x unsigned B; MULHU unsigned.
REQ-020 Sign rules, division: quotient negated when operand signs differ; remainder takes the sign of A.
REQ-021 Result selection: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-022 Divide by zero: quotient = 0xFFFFFFFF, remainder = A; no iterations, DONE on the next edge.
REQ-023 Signed overflow (DIV or REM with A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0; DONE on the next edge.
REQ-024 Iterative latency: done is high exactly 33 cycles after the accept edge. Special cases take 1 cycle.
REQ-025 DONE lasts one cycle, then IDLE unless a new start is accepted; back-to-back issue is allowed.
REQ-026 start while busy=1 is ignored; latched operands, op and rd are unchanged.
REQ-027 flush=1 in MUL or DIV: IDLE on the next edge, no done, result unchanged.
REQ-028 flush and start together: flush wins, nothing is accepted.
REQ-029 result and rd_out hold their values until the next done.

Reset
REQ-030 On reset: state IDLE; busy, done and wr_en = 0; result = 0; rd_out = 0; counter = 0.
REQ-031 Reset mid-operation abandons the op with no done; reset overrides start and flush.

Configuration
REQ-032 Macro MULDIV_FAST_MUL_EN defined: MUL-class ops use a single-cycle 33x33 signed multiply, with done 1 cycle after accept.
REQ-033 MULDIV_FAST_MUL_EN undefined: iterative multiply as in REQ-017. Division is iterative in both builds.

Structure
REQ-034 Package muldiv_pkg holds: the op enum (funct3 encoding), the FSM state enum, and constants DIV0_QUOT=0xFFFFFFFF, OVF_QUOT=0x80000000 and ITER_CNT=32.
REQ-035 One combinational sub-module, operand_cond, produces operand magnitudes and result-sign flags from op, A and B.

Verification
REQ-036 MUL 7 x 0xFFFFFFFD, rd=5 -> result 0xFFFFFFEB; done and wr_en exactly 33 cycles after accept; rd_out=5.
REQ-037 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0x00000000.
REQ-038 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF.
REQ-039 DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, each with done 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, with REM -> 0.
REQ-040 Start accepted, then a second start at cycle 3 and flush at cycle 10 -> second start ignored, busy=0 from cycle 11, no done.
REQ-041 Reset asserted at cycle 15 of a DIV -> no done, all outputs 0 after the edge; a subsequent MUL completes correctly.
REQ-042 rd_in=0 -> done=1 with wr_en=0.
